// File: rtl/icache_direct_pkg.sv
// Shared definitions for the direct-mapped instruction cache: geometry
// defaults, controller state encoding and common logic constants.
package icache_direct_pkg;

    localparam int DEF_INDEX_BITS = 6;
    localparam int DEF_WORD_BITS  = 2;

    localparam logic HIGH  = 1'b1;
    localparam logic LOW   = 1'b0;
    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    typedef enum logic [1:0] {
        IC_IDLE   = 2'd0,
        IC_REQ    = 2'd1,
        IC_REFILL = 2'd2
    } ic_state_t;

endpackage

// File: rtl/icache_direct_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// master: fetch stage plus memory controller; slave: the cache itself.
interface icache_direct_if;
    logic        pc_send_enable;
    logic [31:0] pc_to_ic;
    logic        inst_get_ready;
    logic [31:0] inst_from_ic;
    logic        mem_req_valid;
    logic [31:0] mem_req_addr;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    modport master (
        output pc_send_enable, pc_to_ic, mem_req_ready, mem_resp_valid, mem_resp_data,
        input  inst_get_ready, inst_from_ic, mem_req_valid, mem_req_addr
    );

    modport slave (
        input  pc_send_enable, pc_to_ic, mem_req_ready, mem_resp_valid, mem_resp_data,
        output inst_get_ready, inst_from_ic, mem_req_valid, mem_req_addr
    );
endinterface

// File: rtl/icache_direct_line_store.sv
// Valid/tag/data arrays of the cache. Combinational read port for lookup,
// single write port used by the refill sequencer. Only valid bits reset.
module icache_line_store
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS,
    localparam int TAG_BITS  = 32 - INDEX_BITS - WORD_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_index,
    input  logic [WORD_BITS-1:0]  rd_word,
    input  logic [TAG_BITS-1:0]   rd_tag,
    output logic                  rd_hit,
    output logic [31:0]           rd_data,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [WORD_BITS-1:0]  wr_word,
    input  logic [31:0]           wr_data,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic                  data_we,
    input  logic                  tag_we,
    input  logic                  set_valid,
    input  logic                  clr_valid
);
    localparam int LINES = 1 << INDEX_BITS;
    localparam int WORDS = 1 << WORD_BITS;

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_mem  [LINES];
    logic [31:0]         data_mem [LINES*WORDS];

    assign rd_hit  = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
    assign rd_data = data_mem[{rd_index, rd_word}];

    // Valid bits: cleared when a refill starts, set once the last word lands.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid <= '0;
        end else begin
            if (clr_valid) valid[wr_index] <= LOW;
            if (set_valid) valid[wr_index] <= HIGH;
        end
    end

    // Tag and data storage carry no reset; valid gates every use of them.
    always_ff @(posedge clk) begin
        if (data_we) data_mem[{wr_index, wr_word}] <= wr_data;
        if (tag_we)  tag_mem[wr_index] <= wr_tag;
    end
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache. Hits answer one cycle after the
// request; misses refill a whole line word by word, then re-look-up in IDLE.
//
// state     | meaning
// IC_IDLE   | lookup current fetch address, answer hit or issue refill request
// IC_REQ    | refill request presented, waiting for controller acceptance
// IC_REFILL | collecting line words, ascending order, word 0 first
module icache_direct
    import icache_direct_pkg::*;
#(
    parameter int INDEX_BITS = DEF_INDEX_BITS,
    parameter int WORD_BITS  = DEF_WORD_BITS
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            rdy,
    icache_direct_if.slave  bus
);
    localparam int TAG_BITS = 32 - INDEX_BITS - WORD_BITS - 2;
    localparam int OFF_BITS = WORD_BITS + 2;

    ic_state_t             state;
    logic                  ready_q;
    logic [31:0]           inst_q;
    logic                  req_valid_q;
    logic [31:0]           req_addr_q;
    logic [WORD_BITS-1:0]  cnt;

    logic [TAG_BITS-1:0]   pc_tag;
    logic [INDEX_BITS-1:0] pc_index;
    logic [WORD_BITS-1:0]  pc_word;
    logic [TAG_BITS-1:0]   fill_tag;
    logic [INDEX_BITS-1:0] fill_index;
    logic                  hit;
    logic [31:0]           hit_data;
    logic                  accept;
    logic                  beat;
    logic                  last_beat;
    logic                  unused_bits;

    assign pc_tag   = bus.pc_to_ic[31:OFF_BITS+INDEX_BITS];
    assign pc_index = bus.pc_to_ic[OFF_BITS+INDEX_BITS-1:OFF_BITS];
    assign pc_word  = bus.pc_to_ic[OFF_BITS-1:2];

    // The held request address identifies the line being filled, so a
    // redirected fetch cannot disturb the refill target.
    assign fill_tag   = req_addr_q[31:OFF_BITS+INDEX_BITS];
    assign fill_index = req_addr_q[OFF_BITS+INDEX_BITS-1:OFF_BITS];

    assign unused_bits = ^{bus.pc_to_ic[1:0], req_addr_q[OFF_BITS-1:0]};

    assign accept    = rdy && (state == IC_REQ) && bus.mem_req_ready;
    assign beat      = rdy && (state == IC_REFILL) && bus.mem_resp_valid;
    assign last_beat = beat && (&cnt);

    icache_line_store #(
        .INDEX_BITS (INDEX_BITS),
        .WORD_BITS  (WORD_BITS)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_index  (pc_index),
        .rd_word   (pc_word),
        .rd_tag    (pc_tag),
        .rd_hit    (hit),
        .rd_data   (hit_data),
        .wr_index  (fill_index),
        .wr_word   (cnt),
        .wr_data   (bus.mem_resp_data),
        .wr_tag    (fill_tag),
        .data_we   (beat),
        .tag_we    (last_beat),
        .set_valid (last_beat),
        .clr_valid (accept)
    );

    // The ready pulse is masked while stalled, so a pending answer is held
    // and delivered once rdy returns.
    assign bus.inst_get_ready = ready_q & rdy;
    assign bus.inst_from_ic   = inst_q;
    assign bus.mem_req_valid  = req_valid_q;
    assign bus.mem_req_addr   = req_addr_q;

    // Lookup / refill sequencer; everything freezes while rdy is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IC_IDLE;
            ready_q     <= LOW;
            inst_q      <= '0;
            req_valid_q <= LOW;
            req_addr_q  <= '0;
            cnt         <= '0;
        end else if (rdy) begin
            case (state)
                IC_IDLE: begin
                    if (ready_q) begin
                        // answer cycle: skip lookup so a stale enable is not re-served
                        ready_q <= LOW;
                    end else if (bus.pc_send_enable) begin
                        if (hit) begin
                            ready_q <= HIGH;
                            inst_q  <= hit_data;
                        end else begin
                            req_valid_q <= HIGH;
                            req_addr_q  <= {pc_tag, pc_index, {OFF_BITS{1'b0}}};
                            state       <= IC_REQ;
                        end
                    end
                end
                IC_REQ: begin
                    if (bus.mem_req_ready) begin
                        req_valid_q <= LOW;
                        cnt         <= '0;
                        state       <= IC_REFILL;
                    end
                end
                IC_REFILL: begin
                    if (bus.mem_resp_valid) begin
                        cnt <= cnt + WORD_BITS'(1);
                        if (&cnt) state <= IC_IDLE;
                    end
                end
                default: state <= IC_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache_direct.sv
// Directed bench for icache_direct: cold miss, hits, eviction, redirect,
// reset mid-refill and rdy stalls.
module tb_icache_direct;
    logic clk;
    logic rst;
    logic rdy;
    icache_direct_if bus ();

    int tests_run   = 0;
    int tests_fail  = 0;
    int ready_cnt   = 0;
    int dbl_cnt     = 0;
    int req_cnt     = 0;
    logic prev_ready = 1'b0;
    logic prev_req   = 1'b0;

    icache_direct dut (
        .clk (clk),
        .rst (rst),
        .rdy (rdy),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Event monitor: ready pulses, back-to-back ready, refill requests.
    always @(negedge clk) begin
        if (bus.inst_get_ready) begin
            ready_cnt++;
            if (prev_ready) dbl_cnt++;
        end
        if (bus.mem_req_valid && !prev_req) req_cnt++;
        prev_ready = bus.inst_get_ready;
        prev_req   = bus.mem_req_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Backing memory contents: line 0 holds the known program words.
    function automatic logic [31:0] model_word(input logic [31:0] a);
        if (a[31:4] == 28'd0) begin
            case (a[3:2])
                2'd0:    return 32'h0000_0013;
                2'd1:    return 32'h0000_0011;
                2'd2:    return 32'h0000_0022;
                default: return 32'h0000_0033;
            endcase
        end
        return 32'hA000_0000 | a;
    endfunction

    task automatic wait_req();
        int n = 0;
        while (!bus.mem_req_valid && n < 20) begin
            tick();
            n++;
        end
        check("req_seen", bus.mem_req_valid, 1);
    endtask

    // Memory controller: accept after 'delay' cycles, then 4 back-to-back beats.
    // At beat 'redir' the fetch stage drops enable and moves to 'redir_pc'.
    task automatic refill(input logic [31:0] exp_addr, input int delay,
                          input int redir, input logic [31:0] redir_pc);
        wait_req();
        check("req_addr", bus.mem_req_addr, exp_addr);
        repeat (delay) tick();
        check("req_held", bus.mem_req_valid, 1);
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready = 1'b0;
        check("req_drop", bus.mem_req_valid, 0);
        for (int i = 0; i < 4; i++) begin
            if (i == redir) begin
                bus.pc_send_enable = 1'b0;
                bus.pc_to_ic       = redir_pc;
            end
            bus.mem_resp_valid = 1'b1;
            bus.mem_resp_data  = model_word(exp_addr + 32'(4 * i));
            tick();
        end
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
    endtask

    task automatic fetch_hit(input string tag, input logic [31:0] addr);
        bus.pc_to_ic       = addr;
        bus.pc_send_enable = 1'b1;
        tick();
        check({tag, "_rdy"}, bus.inst_get_ready, 1);
        check({tag, "_data"}, bus.inst_from_ic, model_word(addr));
        bus.pc_send_enable = 1'b0;
        tick();
        check({tag, "_rdy_low"}, bus.inst_get_ready, 0);
    endtask

    task automatic miss_then_ready(input string tag, input logic [31:0] addr, input int delay);
        bus.pc_to_ic       = addr;
        bus.pc_send_enable = 1'b1;
        refill({addr[31:4], 4'h0}, delay, -1, 32'h0);
        check({tag, "_not_yet"}, bus.inst_get_ready, 0);
        tick();
        check({tag, "_rdy"}, bus.inst_get_ready, 1);
        check({tag, "_data"}, bus.inst_from_ic, model_word(addr));
        bus.pc_send_enable = 1'b0;
        tick();
    endtask

    initial begin
        int snap;
        rst = 1'b0;
        rdy = 1'b1;
        bus.pc_send_enable = 1'b0;
        bus.pc_to_ic       = '0;
        bus.mem_req_ready  = 1'b0;
        bus.mem_resp_valid = 1'b0;
        bus.mem_resp_data  = '0;
        repeat (3) tick();
        check("rst_ready", bus.inst_get_ready, 0);
        check("rst_inst", bus.inst_from_ic, 0);
        check("rst_req_valid", bus.mem_req_valid, 0);
        check("rst_req_addr", bus.mem_req_addr, 0);
        rst = 1'b1;
        tick();

        // cold miss on line 0, controller accepts after 2 cycles
        miss_then_ready("cold", 32'h0, 2);
        check("cold_one_req", 32'(req_cnt), 1);

        // hits in the same line
        fetch_hit("hit4", 32'h4);
        fetch_hit("hit8", 32'h8);
        fetch_hit("hitC", 32'hC);
        check("hits_no_req", 32'(req_cnt), 1);

        // enable held through the answer cycle: no second consecutive pulse
        bus.pc_to_ic = 32'h8;
        bus.pc_send_enable = 1'b1;
        tick();
        check("stale_first", bus.inst_get_ready, 1);
        tick();
        check("stale_second", bus.inst_get_ready, 0);
        bus.pc_send_enable = 1'b0;
        tick();

        // conflict eviction: 0x400 shares index 0
        miss_then_ready("evict400", 32'h400, 0);
        miss_then_ready("refetch0", 32'h0, 1);

        // redirect mid-refill: 0x40 misses, fetch jumps to cached 0x0
        snap = ready_cnt;
        bus.pc_to_ic = 32'h40;
        bus.pc_send_enable = 1'b1;
        refill(32'h40, 0, 2, 32'h0);
        check("redir_no_ready", 32'(ready_cnt), 32'(snap));
        bus.pc_send_enable = 1'b1;
        tick();
        check("redir_rdy", bus.inst_get_ready, 1);
        check("redir_data", bus.inst_from_ic, 32'h0000_0013);
        bus.pc_send_enable = 1'b0;
        tick();
        fetch_hit("hit40", 32'h40);

        // reset during beat 1 of a refill
        bus.pc_to_ic = 32'h800;
        bus.pc_send_enable = 1'b1;
        wait_req();
        bus.mem_req_ready = 1'b1;
        tick();
        bus.mem_req_ready  = 1'b0;
        bus.pc_send_enable = 1'b0;
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = 32'hDEAD_0000;
        tick();
        bus.mem_resp_data = 32'hDEAD_0004;
        rst = 1'b0;
        tick();
        check("mrst_req_valid", bus.mem_req_valid, 0);
        check("mrst_ready", bus.inst_get_ready, 0);
        rst = 1'b1;
        snap = req_cnt;
        tick();
        tick();
        bus.mem_resp_valid = 1'b0;
        check("mrst_stray_ignored", 32'(req_cnt), 32'(snap));
        check("mrst_stray_ready", bus.inst_get_ready, 0);
        miss_then_ready("mrst_refetch0", 32'h0, 0);

        // rdy stall while request pending
        bus.pc_to_ic = 32'h80;
        bus.pc_send_enable = 1'b1;
        wait_req();
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_req_valid", bus.mem_req_valid, 1);
            check("stall_req_addr", bus.mem_req_addr, 32'h80);
        end
        rdy = 1'b1;
        refill(32'h80, 1, -1, 32'h0);
        tick();
        check("stall_rdy", bus.inst_get_ready, 1);
        check("stall_data", bus.inst_from_ic, model_word(32'h80));
        bus.pc_send_enable = 1'b0;
        tick();

        // rdy stall over a hit
        bus.pc_to_ic = 32'h84;
        bus.pc_send_enable = 1'b1;
        rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hstall_no_ready", bus.inst_get_ready, 0);
        end
        rdy = 1'b1;
        tick();
        check("hstall_rdy", bus.inst_get_ready, 1);
        check("hstall_data", bus.inst_from_ic, model_word(32'h84));
        bus.pc_send_enable = 1'b0;
        tick();
        tick();

        check("no_double_ready", 32'(dbl_cnt), 0);
        check("total_reqs", 32'(req_cnt), 7);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_fail);
        $finish;
    end
endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache that sits between the instruction-fetch stage and the memory controller.
- Serves fetch requests carried on pc_send_enable/pc_to_ic and answers with a one-cycle inst_get_ready pulse plus inst_from_ic.
- On a miss, refills one full line from the memory controller with a word-per-beat request/response handshake, then services the fetch from the cache.

Parameters:
- INDEX_BITS, 6, log2 of number of lines (64 lines).
- WORD_BITS, 2, log2 of 32-bit words per line (4 words = 16 bytes).
- TAG_BITS, 32-INDEX_BITS-WORD_BITS-2, derived; not overridable.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-low (asserted when 0).
- rdy  in  1  global ready; when 0 the whole block freezes.
- pc_send_enable  in  1  fetch request valid; held high by fetch until serviced.
- pc_to_ic  in  32  fetch address; bits [1:0] ignored.
- inst_get_ready  out  1  one-cycle pulse: inst_from_ic is valid for the current request.
- inst_from_ic  out  32  fetched instruction word.
- mem_req_valid  out  1  line-refill request; held until accepted.
- mem_req_addr  out  32  line-aligned refill address (low WORD_BITS+2 bits zero).
- mem_req_ready  in  1  controller accepts the request this cycle.
- mem_resp_valid  in  1  one refill word present.
- mem_resp_data  in  32  refill word; words arrive in ascending order, word 0 first.

Behaviour:
- Address split:
  - tag = pc[31 : INDEX_BITS+WORD_BITS+2]
  - index = pc[INDEX_BITS+WORD_BITS+1 : WORD_BITS+2]
  - word = pc[WORD_BITS+1 : 2]
- Reset (rst=0, any time): state=IDLE, all valid bits cleared, inst_get_ready=0, inst_from_ic=0, mem_req_valid=0, mem_req_addr=0, refill counter=0. Tag and data arrays are not reset.
- rdy=0: all state held, inst_get_ready forced 0, mem_req_valid held. mem_resp_valid is ignored while rdy=0; the controller must not present beats then.
- State IDLE:
  - If pc_send_enable and inst_get_ready==0 and hit (valid[index] && tag match): next cycle inst_get_ready=1 and inst_from_ic=data[index][word]. Hit latency is 1 cycle.
  - If pc_send_enable and miss: mem_req_valid<=1, mem_req_addr<={tag,index,0}, go to REQ.
  - In the cycle inst_get_ready is 1, no new lookup starts. inst_get_ready is never high on two consecutive cycles, so a stale enable from fetch is not answered twice.
- State REQ: hold mem_req_valid/addr. When mem_req_ready=1, drop mem_req_valid, clear the counter, go to REFILL.
- State REFILL:
  - Each mem_resp_valid beat writes data[index][counter] and increments the counter.
  - On the beat where counter==2^WORD_BITS-1: write the tag, set valid[index], go to IDLE.
  - The pending fetch is then re-looked-up in IDLE and hits. Miss-to-ready latency = request acceptance + 2^WORD_BITS beats + 2 cycles.
- valid[index] is cleared when the refill is accepted, so a partially written line never hits.
- pc_send_enable drops, or pc_to_ic changes, during REQ/REFILL (fetch redirected on a jump): the refill still completes and installs the line, and no inst_get_ready is produced for the abandoned address. IDLE then looks up whatever is current.
- mem_resp_valid outside REFILL is ignored.
- Conflict: a miss on an index holding a different tag overwrites that line, with no write-back.
- No writes or coherence with stores; self-modifying code is unsupported.

Decomposition:
- Shared config.v additions:
  - ICACHE state encodings IDLE/REQ/REFILL (2-bit).
  - Default INDEX_BITS and WORD_BITS macros.
  - Reuse the existing HIGH/LOW/TRUE/FALSE defines.
- One sub-module, icache_line_store: holds the valid, tag and data arrays. It provides a combinational read port (index, word → hit, word) and a write port (index, word, data, tag_we, set_valid, clr_valid). Valid bits reset asynchronously.

Test Plan:
- Cold miss: reset; pc_send_enable=1, pc_to_ic=0x0; memory accepts after 2 cycles and returns 0x00000013, 0x11, 0x22, 0x33 → exactly one mem_req with addr 0x0, then inst_get_ready pulse with inst_from_ic=0x00000013 two cycles after the last beat.
- Hits in the same line: after the cold miss, request 0x4, 0x8, 0xC → each answered one cycle after enable with 0x11, 0x22, 0x33; no mem_req; ready never high two cycles in a row.
- Conflict eviction: line 0x0 cached; request 0x400 (same index, different tag) → refill at addr 0x400; a later request to 0x0 misses again and refills at 0x0.
- Redirect mid-refill: request 0x40 misses; during beat 2, drop pc_send_enable and request 0x0 (cached) → refill finishes, no ready for 0x40; ready with the 0x0 data after return to IDLE; a later 0x40 request hits.
- Reset mid-refill: assert rst=0 during beat 1 of a refill, release → mem_req_valid=0, state IDLE; re-request of 0x0 misses (valid cleared); stray mem_resp_valid after reset ignored.
- rdy stall: deassert rdy for 3 cycles mid-REQ and mid-hit → no ready pulse during the stall; request and data delivered unchanged after rdy returns.
